// File: rtl/fetch_ctrl_if.sv
// Instruction-bus handshake between the fetch sequencer (master) and instruction memory (slave).
// A request is acknowledged by a single-cycle ack, and the read data is valid in that same cycle.
interface fetch_ctrl_if;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack;
    logic [31:0] ibus_rdata;

    modport master (output ibus_req, ibus_addr, input ibus_ack, ibus_rdata);
    modport slave  (input ibus_req, ibus_addr, output ibus_ack, ibus_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// MIPS32 instruction-fetch sequencer: owns the PC, arbitrates flush > branch > sequential,
// and feeds IF/ID through an output register backed by a one-entry skid buffer.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_flag,
    input  logic [31:0]        branch_target,
    input  logic               flush,
    input  logic [31:0]        new_pc,
    fetch_ctrl_if.master       ibus,
    output logic               inst_valid,
    output logic [31:0]        inst,
    output logic [31:0]        inst_pc
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        req;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;
    logic        redir_pend;
    logic        redir_discard;
    logic [31:0] redir_addr;

    logic        redirect;
    logic [31:0] target;
    logic        consume;
    logic        slot_free;
    logic        drop_ack;

    assign redirect  = flush | branch_flag;
    assign target    = flush ? {new_pc[31:2], 2'b00} : {branch_target[31:2], 2'b00};
    assign consume   = inst_valid & ~stall;
    assign slot_free = ~inst_valid | ~stall;
    // A word is dropped if a flush arrives with it or one was recorded while it was in flight.
    assign drop_ack  = flush | (redir_pend & redir_discard);

    assign ibus.ibus_req  = req;
    assign ibus.ibus_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= BOOT;
            pc            <= RESET_PC;
            req           <= 1'b0;
            inst_valid    <= 1'b0;
            inst          <= '0;
            inst_pc       <= '0;
            skid_inst     <= '0;
            skid_pc       <= '0;
            redir_pend    <= 1'b0;
            redir_discard <= 1'b0;
            redir_addr    <= '0;
        end else begin
            // NOTE: this default clear is overridden by any later non-blocking write to
            // inst_valid in the same edge, which is how "consume and reload" is expressed.
            if (consume) inst_valid <= 1'b0;

            unique case (state)
                BOOT: begin
                    state <= FETCH;
                    req   <= 1'b1;
                    if (redirect) pc <= target;
                end

                FETCH: begin
                    if (ibus.ibus_ack) begin
                        if (!drop_ack) begin
                            if (slot_free) begin
                                inst       <= ibus.ibus_rdata;
                                inst_pc    <= pc;
                                inst_valid <= 1'b1;
                            end else begin
                                skid_inst <= ibus.ibus_rdata;
                                skid_pc   <= pc;
                                state     <= HOLD;
                                req       <= 1'b0;
                            end
                        end
                        if (flush) inst_valid <= 1'b0;
                        if (redirect)        pc <= target;
                        else if (redir_pend) pc <= redir_addr;
                        else                 pc <= pc + 32'd4;
                        redir_pend    <= 1'b0;
                        redir_discard <= 1'b0;
                    end else if (redirect) begin
                        // Address is locked while the request is outstanding; apply it on the ack.
                        redir_pend    <= 1'b1;
                        redir_addr    <= target;
                        redir_discard <= redir_discard | flush;
                        if (flush) inst_valid <= 1'b0;
                    end
                end

                HOLD: begin
                    if (redirect) pc <= target;
                    if (flush) begin
                        inst_valid <= 1'b0;
                        state      <= FETCH;
                        req        <= 1'b1;
                    end else if (!stall) begin
                        inst       <= skid_inst;
                        inst_pc    <= skid_pc;
                        inst_valid <= 1'b1;
                        state      <= FETCH;
                        req        <= 1'b1;
                    end
                end

                default: begin
                    state <= BOOT;
                    req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the MIPS32 core.
- Owns the program counter and issues fetches over a req/ack instruction bus.
- Arbitrates next-PC sources: flush/exception, then branch, then sequential.
- Presents fetched words to the IF/ID stage through a 1-entry output register plus a 1-entry skid buffer, so a pipeline stall never loses an acknowledged word.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset; first fetch address.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- stall  input  1  IF/ID hold; the word in inst must not change while inst_valid=1 and stall=1.
- branch_flag  input  1  branch/jump resolved in ID; the in-flight delay-slot fetch is kept.
- branch_target  input  32  branch destination.
- flush  input  1  exception/eret redirect; all fetched-but-unissued words are discarded.
- new_pc  input  32  flush destination.
- ibus_req  output  1  fetch request.
- ibus_addr  output  32  fetch address; equals pc.
- ibus_ack  input  1  single-cycle completion; ibus_rdata is valid in the same cycle.
- ibus_rdata  input  32  fetched word.
- inst_valid  output  1  inst/inst_pc hold a valid instruction.
- inst  output  32  instruction to IF/ID.
- inst_pc  output  32  address of inst.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC; state=BOOT; ibus_req=0.
  - inst_valid=0, inst=0, inst_pc=0.
  - skid empty; redirect-pending cleared.
- States:
  - BOOT → FETCH unconditionally on the first clock after reset release. ibus_req stays 0 in BOOT, so the first request is in the 2nd cycle after release.
  - FETCH: ibus_req=1. ibus_addr and pc must not change while ibus_req=1 and no ack has arrived.
  - HOLD: ibus_req=0; skid is full.
- Consume rule: IF/ID takes inst on any edge with inst_valid=1 and stall=0. inst_valid then drops to 0 unless a new word is loaded on the same edge.
- Ack in FETCH, no redirect pending or arriving:
  - Slot free (inst_valid=0 or stall=0): inst<=ibus_rdata, inst_pc<=pc, inst_valid<=1. pc<=pc+4; stay in FETCH, so back-to-back fetches are allowed.
  - Slot occupied (inst_valid=1 and stall=1): skid<={ibus_rdata, pc}; pc<=pc+4; go to HOLD.
- HOLD: when stall=0, inst<=skid, inst_valid stays 1, skid is emptied, go to FETCH.
- Redirect priority: flush > branch_flag. Target bits [1:0] are forced to 00.
- Redirect in BOOT or HOLD, or in FETCH with ibus_ack=1 in the same cycle, takes effect at once: pc<=target.
  - Flush additionally: drops any word acked this cycle, clears skid and inst_valid, goes to FETCH.
  - Branch: keeps the word acked this cycle as the delay slot, loaded per the normal rules; keeps skid/inst.
- Redirect in FETCH with ibus_req=1 and ibus_ack=0: the address is locked, so record redir_pend=1, redir_addr=target, and set redir_discard |= flush.
  - Flush also clears inst_valid and skid immediately.
  - A later redirect before the ack overwrites redir_addr; redir_discard stays sticky.
  - On the ack: if redir_discard, drop the data, else load it normally. Then pc<=redir_addr and clear the pending state.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Reset mid-transaction: all state returns to reset values. An ack arriving in BOOT is ignored.
- The pc register is not exposed directly; observe it through ibus_addr.

Test Plan:
- Reset release, immediate ack every request → ibus_req first high in cycle 2. Fetches in order: 0x0, 0x4, 0x8. inst_pc/inst_valid follow one cycle after each ack.
- stall=1 held for 3 cycles with inst valid and an ack arriving → inst unchanged and the acked word goes to skid; ibus_req=0 while in HOLD. When stall drops, inst=skid word; the next fetch address is the skid address +4.
- branch_flag with branch_target=0x100, raised while the request to 0x8 is outstanding, ack 2 cycles later → 0x8 word delivered as delay slot; next ibus_addr=0x100.
- flush with new_pc=0x180 while the request to 0x10 is outstanding and inst valid → inst_valid=0 next cycle; 0x10 data dropped at ack; next ibus_addr=0x180.
- flush and branch_flag in the same cycle as an ack (new_pc=0x180, target=0x200) → acked word dropped; next ibus_addr=0x180.
- RESET_PC=0xFFFF_FFFC, immediate acks → second fetch address is 0x0; rst pulsed low mid-request → ibus_req=0 and inst_valid=0 asynchronously.
